proj_extender_stream: RTL

//  Streaming successor to the fixed-rate extender, with handshakes and reference-edge padding.

---
 rtl/proj_extender_stream.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/proj_extender_stream.sv
// proj_extender_stream
//   Streaming fragment extender placed between the minhash sorter and the GFM
//   stage. A batch of k-mer start indices is accepted, one fragment window is
//   requested from memory per index, and each window is emitted as
//   PART_BASES-wide one-hot parts under valid/ready. Bases that fall outside
//   the reference [0, REF_LEN) are emitted as all-zero pad.
//   Optional feature macro: PROJ_EXTENDER_REVCOMP_EN
//     defined   -> batches latched with in_strand=1 are emitted reverse-complemented
//     undefined -> forward order only; in_strand is ignored
module proj_extender_stream #(
   parameter int FRAG_SIZE         = 16,
   parameter int KMER_SIZE         = 4,
   parameter int INDICES_COUNT     = 4,
   parameter int INDICE_LEN        = 8,
   parameter int SIGNED_INDICE_LEN = 9,
   parameter int PART_BASES        = 4,
   parameter int REF_LEN           = 64,
   parameter int BASE_LEN          = 2,
   parameter int ONE_HOT_LEN       = 4
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [INDICES_COUNT*INDICE_LEN-1:0]   in_kmer_indices,
   input  logic [$clog2(INDICES_COUNT+1)-1:0]    in_count,
   input  logic                                  in_strand,
   output logic                                  out_fetch_valid,
   output logic [SIGNED_INDICE_LEN-1:0]          out_index,
   input  logic                                  in_frag_valid,
   input  logic [FRAG_SIZE*BASE_LEN-1:0]         in_fragment,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [PART_BASES*ONE_HOT_LEN-1:0]     out_gfm,
   output logic [$clog2(INDICES_COUNT)-1:0]      out_kmer_idx,
   output logic [$clog2(FRAG_SIZE/PART_BASES)-1:0] out_part_idx,
   output logic                                  out_last,
   output logic                                  out_done
);

   localparam int OFFSET    = (FRAG_SIZE - KMER_SIZE) / 2;
   localparam int NUM_PARTS = FRAG_SIZE / PART_BASES;
   localparam int CNT_W     = $clog2(INDICES_COUNT + 1);
   localparam int SLOT_W    = $clog2(INDICES_COUNT);
   localparam int PART_W    = $clog2(NUM_PARTS);
   localparam int PBITS     = PART_BASES * ONE_HOT_LEN;
   localparam int WIN_W     = FRAG_SIZE * ONE_HOT_LEN;
   localparam int POS_W     = SIGNED_INDICE_LEN + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_EMIT  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   // Window start is centred on the k-mer; it may go negative near the left edge.
   function automatic logic [SIGNED_INDICE_LEN-1:0] window_start(input logic [INDICE_LEN-1:0] idx);
      return SIGNED_INDICE_LEN'({1'b0, idx}) - SIGNED_INDICE_LEN'(OFFSET);
   endfunction

   // Converts a packed fragment into the full one-hot window with pad bases zeroed.
   // In reverse mode output base j takes the complement of window base FRAG_SIZE-1-j,
   // and the pad test uses that same source position so padding follows its base.
`ifdef PROJ_EXTENDER_REVCOMP_EN
   function automatic logic [WIN_W-1:0] build_window(input logic [FRAG_SIZE*BASE_LEN-1:0] frag,
                                                     input logic [SIGNED_INDICE_LEN-1:0] start,
                                                     input logic rev);
`else
   function automatic logic [WIN_W-1:0] build_window(input logic [FRAG_SIZE*BASE_LEN-1:0] frag,
                                                     input logic [SIGNED_INDICE_LEN-1:0] start);
`endif
      logic [WIN_W-1:0]        win;
      logic signed [POS_W-1:0] pos;
      logic [BASE_LEN-1:0]     code;
      int                      src;
      win = '0;
      for (int j = 0; j < FRAG_SIZE; j++) begin
`ifdef PROJ_EXTENDER_REVCOMP_EN
         src  = rev ? (FRAG_SIZE - 1 - j) : j;
         code = frag[src*BASE_LEN +: BASE_LEN];
         code = rev ? ~code : code;
`else
         src  = j;
         code = frag[src*BASE_LEN +: BASE_LEN];
`endif
         pos = $signed({start[SIGNED_INDICE_LEN-1], start}) + $signed(POS_W'(src));
         if (pos[POS_W-1] || (pos >= $signed(POS_W'(REF_LEN)))) begin
            win[j*ONE_HOT_LEN +: ONE_HOT_LEN] = '0;
         end else begin
            win[j*ONE_HOT_LEN +: ONE_HOT_LEN] = ONE_HOT_LEN'(1'b1) << code;
         end
      end
      return win;
   endfunction

   logic [1:0]                          state_q, state_d;
   logic [INDICES_COUNT*INDICE_LEN-1:0] indices_q, indices_d;
   logic [CNT_W-1:0]                    count_q, count_d;
   logic [SLOT_W-1:0]                   slot_q, slot_d;
   logic [PART_W-1:0]                   part_q, part_d;
   logic [SIGNED_INDICE_LEN-1:0]        index_q, index_d;
   logic [WIN_W-1:0]                    window_q, window_d;
`ifdef PROJ_EXTENDER_REVCOMP_EN
   logic                                strand_q, strand_d;
`else
   logic                                unused_strand_s;
   assign unused_strand_s = in_strand;
`endif

   logic              last_part_s;
   logic              last_slot_s;
   logic [SLOT_W-1:0] next_slot_s;

   assign last_part_s = (part_q == PART_W'(NUM_PARTS - 1));
   assign last_slot_s = ((CNT_W'(slot_q) + CNT_W'(1'b1)) == count_q);
   assign next_slot_s = slot_q + SLOT_W'(1'b1);

   // Next-state and datapath updates for the batch / fetch / emit sequencer.
   always_comb begin
      state_d   = state_q;
      indices_d = indices_q;
      count_d   = count_q;
      slot_d    = slot_q;
      part_d    = part_q;
      index_d   = index_q;
      window_d  = window_q;
`ifdef PROJ_EXTENDER_REVCOMP_EN
      strand_d  = strand_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               indices_d = in_kmer_indices;
               count_d   = in_count;
               slot_d    = '0;
               part_d    = '0;
               index_d   = window_start(in_kmer_indices[INDICE_LEN-1:0]);
`ifdef PROJ_EXTENDER_REVCOMP_EN
               strand_d  = in_strand;
`endif
               if (in_count == '0) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_FETCH;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_FETCH: begin
            if (in_frag_valid) begin
`ifdef PROJ_EXTENDER_REVCOMP_EN
               window_d = build_window(in_fragment, index_q, strand_q);
`else
               window_d = build_window(in_fragment, index_q);
`endif
               part_d   = '0;
               state_d  = S_EMIT;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_EMIT: begin
            if (out_ready) begin
               if (last_part_s) begin
                  part_d = '0;
                  if (last_slot_s) begin
                     state_d = S_DONE;
                  end else begin
                     slot_d  = next_slot_s;
                     index_d = window_start(indices_q[next_slot_s*INDICE_LEN +: INDICE_LEN]);
                     state_d = S_FETCH;
                  end
               end else begin
                  part_d = part_q + PART_W'(1'b1);
               end
            end else begin
               state_d = S_EMIT;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any batch in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         indices_q <= '0;
         count_q   <= '0;
         slot_q    <= '0;
         part_q    <= '0;
         index_q   <= '0;
         window_q  <= '0;
`ifdef PROJ_EXTENDER_REVCOMP_EN
         strand_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         indices_q <= indices_d;
         count_q   <= count_d;
         slot_q    <= slot_d;
         part_q    <= part_d;
         index_q   <= index_d;
         window_q  <= window_d;
`ifdef PROJ_EXTENDER_REVCOMP_EN
         strand_q  <= strand_d;
`endif
      end
   end

   // All outputs decode directly from registers, so they hold steady under backpressure.
   assign in_ready        = (state_q == S_IDLE);
   assign out_fetch_valid = (state_q == S_FETCH);
   assign out_index       = index_q;
   assign out_valid       = (state_q == S_EMIT);
   assign out_gfm         = (state_q == S_EMIT) ? window_q[part_q*PBITS +: PBITS] : '0;
   assign out_kmer_idx    = slot_q;
   assign out_part_idx    = part_q;
   assign out_last        = (state_q == S_EMIT) && last_part_s && last_slot_s;
   assign out_done        = (state_q == S_DONE);

endmodule
